// File: rtl/bcd_operand_entry.sv
// bcd_operand_entry: edits a NUM_DIGITS BCD operand from button pulses and holds it with a valid/ack handshake
module bcd_operand_entry #(
  parameter int NUM_DIGITS   = 3,
  parameter int SEL_W        = 2,
  parameter int CLEAR_ON_ACK = 1
) (
  input  logic                    clk,
  input  logic                    resetPulse,
  input  logic                    incPulse,
  input  logic                    decPulse,
  input  logic                    selPulse,
  input  logic                    clearPulse,
  input  logic                    enterPulse,
  input  logic                    operandAck,
  output logic [4*NUM_DIGITS-1:0] operand,
  output logic [SEL_W-1:0]        digitSel,
  output logic                    operandValid,
  output logic                    editActive
);
  typedef enum logic {EDIT, HOLD} state_t;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);
  state_t state;
  logic [4*NUM_DIGITS-1:0] nextOperand;
  logic [3:0] d;
  // only the selected digit moves; wrap inside 0..9 with no carry/borrow
  always_comb begin
    nextOperand = operand;
    d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = operand[i*4 +: 4];
      if (digitSel == SEL_W'(i))
        nextOperand[i*4 +: 4] = incPulse ? (d == 4'd9 ? 4'd0 : d + 4'd1)
                                         : (d == 4'd0 ? 4'd9 : d - 4'd1);
    end
  end
  always_ff @(posedge clk or negedge resetPulse) begin
    if (!resetPulse) begin
      state        <= EDIT;
      operand      <= '0;
      digitSel     <= '0;
      operandValid <= 1'b0;
      editActive   <= 1'b1;
    end else if (state == EDIT) begin
      if (clearPulse) begin
        operand  <= '0;
        digitSel <= '0;
      end else if (enterPulse) begin
        state        <= HOLD;
        operandValid <= 1'b1;
        editActive   <= 1'b0;
      end else if (selPulse)
        digitSel <= (digitSel == LAST_SEL) ? '0 : digitSel + 1'b1;
      else if (incPulse ^ decPulse)
        operand <= nextOperand;
    end else if (clearPulse || operandAck) begin
      state        <= EDIT;
      operandValid <= 1'b0;
      editActive   <= 1'b1;
      if (clearPulse || CLEAR_ON_ACK != 0) begin
        operand  <= '0;
        digitSel <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bcd_operand_entry.sv
// tb_bcd_operand_entry: runs a clear-on-ack and a keep-on-ack instance side by side against a digit-array model
module tb_bcd_operand_entry;
  localparam int N = 3;
  logic clk = 0, resetPulse = 0;
  logic incPulse = 0, decPulse = 0, selPulse = 0, clearPulse = 0, enterPulse = 0, operandAck = 0;
  logic [4*N-1:0] opA, opB;
  logic [1:0] selA, selB;
  logic vA, vB, eA, eB;
  int passed = 0, total = 0;
  int dig[2][N];
  int sel[2];
  bit hold[2];

  bcd_operand_entry #(.NUM_DIGITS(N), .SEL_W(2), .CLEAR_ON_ACK(1)) dutA (
    .clk(clk), .resetPulse(resetPulse), .incPulse(incPulse), .decPulse(decPulse),
    .selPulse(selPulse), .clearPulse(clearPulse), .enterPulse(enterPulse), .operandAck(operandAck),
    .operand(opA), .digitSel(selA), .operandValid(vA), .editActive(eA));
  bcd_operand_entry #(.NUM_DIGITS(N), .SEL_W(2), .CLEAR_ON_ACK(0)) dutB (
    .clk(clk), .resetPulse(resetPulse), .incPulse(incPulse), .decPulse(decPulse),
    .selPulse(selPulse), .clearPulse(clearPulse), .enterPulse(enterPulse), .operandAck(operandAck),
    .operand(opB), .digitSel(selB), .operandValid(vB), .editActive(eB));

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int packed_op(int k);
    int v = 0;
    for (int i = N - 1; i >= 0; i--) v = v * 16 + dig[k][i];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) dig[k][i] = 0;
      sel[k] = 0;
      hold[k] = 0;
    end
  endtask

  task automatic model_step(bit inc, bit dec, bit sp, bit clr, bit ent, bit ack);
    for (int k = 0; k < 2; k++) begin
      if (!hold[k]) begin
        if (clr) begin
          for (int i = 0; i < N; i++) dig[k][i] = 0;
          sel[k] = 0;
        end else if (ent) hold[k] = 1;
        else if (sp) sel[k] = (sel[k] + 1) % N;
        else if (inc != dec) dig[k][sel[k]] = (dig[k][sel[k]] + (inc ? 1 : 9)) % 10;
      end else if (clr || ack) begin
        hold[k] = 0;
        if (clr || k == 0) begin
          for (int i = 0; i < N; i++) dig[k][i] = 0;
          sel[k] = 0;
        end
      end
    end
  endtask

  task automatic check_all(string tag);
    check({tag, "_opA"}, 32'(opA), packed_op(0));
    check({tag, "_opB"}, 32'(opB), packed_op(1));
    check({tag, "_selA"}, 32'(selA), sel[0]);
    check({tag, "_selB"}, 32'(selB), sel[1]);
    check({tag, "_validA"}, 32'(vA), 32'(hold[0]));
    check({tag, "_validB"}, 32'(vB), 32'(hold[1]));
    check({tag, "_editA"}, 32'(eA), 32'(!hold[0]));
    check({tag, "_editB"}, 32'(eB), 32'(!hold[1]));
  endtask

  task automatic step(string tag, bit inc, bit dec, bit sp, bit clr, bit ent, bit ack);
    incPulse = inc; decPulse = dec; selPulse = sp;
    clearPulse = clr; enterPulse = ent; operandAck = ack;
    @(posedge clk);
    #1;
    model_step(inc, dec, sp, clr, ent, ack);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset_editA", 32'(eA), 1);
    resetPulse = 1;
    // 1: basic editing
    repeat (3) step("t1_inc", 1, 0, 0, 0, 0, 0);
    step("t1_sel", 0, 0, 1, 0, 0, 0);
    repeat (2) step("t1_inc", 1, 0, 0, 0, 0, 0);
    check("t1_op", 32'(opA), 32'h023);
    check("t1_sel", 32'(selA), 1);
    check("t1_valid", 32'(vA), 0);
    // 2/3: digit wrap and selection wrap
    step("t2_clr", 0, 0, 0, 1, 0, 0);
    step("t2_sel", 0, 0, 1, 0, 0, 0);
    repeat (2) step("t2_inc", 1, 0, 0, 0, 0, 0);
    step("t2_sel", 0, 0, 1, 0, 0, 0);
    check("t3_sel2", 32'(selA), 2);
    step("t3_selwrap", 0, 0, 1, 0, 0, 0);
    check("t3_sel0", 32'(selA), 0);
    step("t2_dec0", 0, 1, 0, 0, 0, 0);
    check("t2_dec0", 32'(opA), 32'h029);
    step("t2_inc9", 1, 0, 0, 0, 0, 0);
    check("t2_inc9", 32'(opA), 32'h020);
    step("t2_dec0b", 0, 1, 0, 0, 0, 0);
    check("t2_dec0b", 32'(opA), 32'h029);
    step("t3_incdec", 1, 1, 0, 0, 0, 0);
    check("t3_incdec", 32'(opA), 32'h029);
    // 4: commit, hold, ack
    step("t4_clr", 0, 0, 0, 1, 0, 0);
    repeat (3) step("t4_inc", 1, 0, 0, 0, 0, 0);
    step("t4_sel", 0, 0, 1, 0, 0, 0);
    repeat (2) step("t4_inc", 1, 0, 0, 0, 0, 0);
    step("t4_sel", 0, 0, 1, 0, 0, 0);
    step("t4_inc", 1, 0, 0, 0, 0, 0);
    check("t4_built", 32'(opA), 32'h123);
    step("t4_enter", 0, 0, 0, 0, 1, 0);
    check("t4_valid", 32'(vA), 1);
    repeat (5) step("t4_hold", 1, 0, 1, 0, 1, 0);
    check("t4_holdop", 32'(opA), 32'h123);
    step("t4_ack", 0, 0, 0, 0, 0, 1);
    check("t4_ackvalid", 32'(vA), 0);
    check("t4_ackopA", 32'(opA), 32'h000);
    check("t4_ackopB", 32'(opB), 32'h123);
    check("t4_acksB", 32'(selB), 2);
    // 5: clear beats enter; clear beats ack in HOLD
    step("t5_clrent", 0, 0, 0, 1, 1, 0);
    check("t5_validA", 32'(vA), 0);
    check("t5_opB", 32'(opB), 0);
    step("t5_inc", 1, 0, 0, 0, 0, 0);
    step("t5_enter", 0, 0, 0, 0, 1, 0);
    step("t5_clrack", 0, 0, 0, 1, 0, 1);
    check("t5_clrack_opB", 32'(opB), 0);
    check("t5_clrack_edit", 32'(eB), 1);
    // 6: async reset during HOLD
    step("t6_inc", 1, 0, 0, 0, 0, 0);
    step("t6_enter", 0, 0, 0, 0, 1, 0);
    step("t6_idle", 0, 0, 0, 0, 0, 0);
    #2 resetPulse = 0;
    #1;
    check("t6_async_valid", 32'(vA), 0);
    check("t6_async_op", 32'(opB), 0);
    model_reset();
    #2 resetPulse = 1;
    step("t6_resume", 1, 0, 0, 0, 0, 0);
    check("t6_resume_op", 32'(opA), 32'h001);
    // randomized pulse traffic
    for (int n = 0; n < 400; n++)
      step("rand", $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(4) == 0,
           $urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(2) == 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
